// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter:
// FSM states, data-bit-count codes and the minimum bit divisor.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2
   } tx_state_t;

   typedef enum logic [1:0] {
      DBITS_5 = 2'b00,
      DBITS_6 = 2'b01,
      DBITS_7 = 2'b10,
      DBITS_8 = 2'b11
   } data_bits_t;

   localparam int unsigned MIN_CLKS_PER_BIT = 2;

   // Index of the final data bit (4..7 for 5..8 data bits).
   function automatic logic [2:0] last_data_idx(input data_bits_t bits);
      return {1'b1, bits};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, head word visible combinationally,
// occupancy count kept in a register so full/empty never see same-cycle pops.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     i_CLK,
   input  logic                     i_RSTN,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge i_CLK) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..8 data bits, optional parity,
// one or two stop bits, programmable bit period, buffered by a small FIFO.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLKDIV_W   = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          i_CLK,
   input  logic                          i_RSTN,
   input  logic                          i_Tx_DV,
   input  logic [7:0]                    i_Tx_Byte,
   input  logic [CLKDIV_W-1:0]           i_Clks_Per_Bit,
   input  logic [1:0]                    i_Data_Bits,
   input  logic                          i_Parity_En,
   input  logic                          i_Parity_Odd,
   input  logic                          i_Two_Stop,
   output logic                          o_Tx_Ready,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Done,
   output logic                          o_Overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

   tx_state_t           state_r, state_nxt;
   logic [CLKDIV_W-1:0] div_r, div_cnt_r;
   logic [2:0]          bit_idx_r;
   logic [7:0]          shift_r;
   logic                parity_r;
   data_bits_t          dbits_r;
   logic                par_en_r, par_odd_r, two_stop_r;

   logic                fifo_full, fifo_empty, fifo_pop;
   logic [7:0]          fifo_q;
   logic                bit_end, serial_d, done_d;

   assign o_Tx_Ready = !fifo_full;
   assign fifo_pop   = (state_r == ST_IDLE) && !fifo_empty;
   assign bit_end    = (div_cnt_r == div_r - 1'b1);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_CLK   (i_CLK),
      .i_RSTN  (i_RSTN),
      .push    (i_Tx_DV),
      .pop     (fifo_pop),
      .wr_data (i_Tx_Byte),
      .rd_data (fifo_q),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (o_Fifo_Count)
   );

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) state_r <= ST_IDLE;
      else         state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE:   if (!fifo_empty) state_nxt = ST_START;
         ST_START:  if (bit_end) state_nxt = ST_DATA;
         ST_DATA:   if (bit_end && bit_idx_r == last_data_idx(dbits_r))
                       state_nxt = par_en_r ? ST_PARITY : ST_STOP1;
         ST_PARITY: if (bit_end) state_nxt = ST_STOP1;
         ST_STOP1:  if (bit_end) state_nxt = two_stop_r ? ST_STOP2 : ST_IDLE;
         ST_STOP2:  if (bit_end) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Line value is chosen for the state being entered so the serial register
   // changes on the same edge as the state register.
   always_comb begin
      serial_d    = 1'b1;
      done_d      = (state_r != ST_IDLE) && (state_nxt == ST_IDLE);
      o_Tx_Active = (state_r != ST_IDLE);
      case (state_nxt)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = (state_r == ST_DATA && bit_end) ? shift_r[1] : shift_r[0];
         ST_PARITY: serial_d = (state_r == ST_DATA) ? (parity_r ^ shift_r[0]) : parity_r;
         default:   serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         o_Tx_Serial <= 1'b1;
         o_Tx_Done   <= 1'b0;
         o_Overflow  <= 1'b0;
         div_r       <= '0;
         div_cnt_r   <= '0;
         bit_idx_r   <= '0;
         shift_r     <= '0;
         parity_r    <= 1'b0;
         dbits_r     <= DBITS_8;
         par_en_r    <= 1'b0;
         par_odd_r   <= 1'b0;
         two_stop_r  <= 1'b0;
      end else begin
         o_Tx_Serial <= serial_d;
         o_Tx_Done   <= done_d;
         o_Overflow  <= i_Tx_DV && fifo_full;
         if (fifo_pop) begin
            shift_r    <= fifo_q;
            div_r      <= (i_Clks_Per_Bit < CLKDIV_W'(MIN_CLKS_PER_BIT)) ?
                          CLKDIV_W'(MIN_CLKS_PER_BIT) : i_Clks_Per_Bit;
            dbits_r    <= data_bits_t'(i_Data_Bits);
            par_en_r   <= i_Parity_En;
            par_odd_r  <= i_Parity_Odd;
            two_stop_r <= i_Two_Stop;
            // Seeding with the odd flag makes the accumulator end on the parity bit.
            parity_r   <= i_Parity_Odd;
            div_cnt_r  <= '0;
            bit_idx_r  <= '0;
         end else if (state_r != ST_IDLE) begin
            if (bit_end) begin
               div_cnt_r <= '0;
               if (state_r == ST_DATA) begin
                  shift_r   <= shift_r >> 1;
                  parity_r  <= parity_r ^ shift_r[0];
                  bit_idx_r <= bit_idx_r + 1'b1;
               end
            end else begin
               div_cnt_r <= div_cnt_r + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued at write time,
// a line monitor pops and compares them cycle by cycle.
module tb_uart_tx_cfg;

   typedef struct {
      logic [11:0] bits;
      int          nbits;
      int          d;
      int          exp_start;   // >=0 absolute cycle, -2 back-to-back, -1 don't care
      logic [7:0]  data;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_dv = 1'b0;
   logic [7:0]  tx_byte = '0;
   logic [15:0] cfg_cpb = 16'd4;
   logic [1:0]  cfg_db = 2'b11;
   logic        cfg_pen = 1'b0;
   logic        cfg_podd = 1'b0;
   logic        cfg_two = 1'b0;
   logic        tx_ready, tx_serial, tx_active, tx_done, overflow;
   logic [2:0]  fifo_count;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   frame_t      exp_q[$];
   frame_t      cur;
   logic        in_frame = 1'b0;
   logic        done_due = 1'b0;
   int          pos, first_bad, bad_got, bad_exp, last_done;

   uart_tx_cfg #(.CLKDIV_W(16), .FIFO_DEPTH(4)) dut (
      .i_CLK          (clk),
      .i_RSTN         (rst_n),
      .i_Tx_DV        (tx_dv),
      .i_Tx_Byte      (tx_byte),
      .i_Clks_Per_Bit (cfg_cpb),
      .i_Data_Bits    (cfg_db),
      .i_Parity_En    (cfg_pen),
      .i_Parity_Odd   (cfg_podd),
      .i_Two_Stop     (cfg_two),
      .o_Tx_Ready     (tx_ready),
      .o_Tx_Serial    (tx_serial),
      .o_Tx_Active    (tx_active),
      .o_Tx_Done      (tx_done),
      .o_Overflow     (overflow),
      .o_Fifo_Count   (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input logic ok, input string name, input int act, input int expv);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Frame built from the current configuration inputs, which the stimulus
   // keeps stable until the byte has been popped.
   function automatic frame_t mk_frame(input logic [7:0] b, input int es);
      frame_t f;
      int     n, k;
      logic   p;
      n         = 5 + int'(cfg_db);
      f.d       = (cfg_cpb < 2) ? 2 : int'(cfg_cpb);
      f.bits    = '1;
      f.data    = b;
      f.exp_start = es;
      k         = 0;
      f.bits[k] = 1'b0;
      k++;
      p = cfg_podd;
      for (int i = 0; i < n; i++) begin
         f.bits[k] = b[i];
         p = p ^ b[i];
         k++;
      end
      if (cfg_pen) begin
         f.bits[k] = p;
         k++;
      end
      k += cfg_two ? 2 : 1;
      f.nbits = k;
      return f;
   endfunction

   // mode: 1 = DUT idle and empty (latency checked), 2 = back-to-back, 0 = don't care
   task automatic write_byte(input logic [7:0] b, input int mode);
      int t;
      int es;
      t = 0;
      while (!tx_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk(tx_ready, "ready_timeout", int'(tx_ready), 1);
      es = (mode == 1) ? cyc + 2 : ((mode == 2) ? -2 : -1);
      tx_dv   = 1'b1;
      tx_byte = b;
      exp_q.push_back(mk_frame(b, es));
      @(negedge clk);
      tx_dv = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || in_frame || done_due) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) chk(1'b0, "drain_timeout", exp_q.size(), 0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 1'b0;
         done_due = 1'b0;
      end else if (done_due) begin
         done_due  = 1'b0;
         last_done = cyc;
         chk(tx_done === 1'b1 && tx_active === 1'b0 && tx_serial === 1'b1,
             "done_pulse", int'({tx_done, tx_active, tx_serial}), 3'b101);
      end else begin
         if (!in_frame && tx_serial === 1'b0) begin
            chk(exp_q.size() > 0, "unexpected_start", 0, 1);
            if (exp_q.size() > 0) begin
               cur       = exp_q.pop_front();
               in_frame  = 1'b1;
               pos       = 0;
               first_bad = -1;
               if (cur.exp_start >= 0)
                  chk(cyc == cur.exp_start, "start_latency", cyc, cur.exp_start);
               else if (cur.exp_start == -2)
                  chk(cyc == last_done + 1, "idle_gap", cyc - last_done, 1);
            end
         end
         if (in_frame) begin
            if ((tx_serial !== cur.bits[pos / cur.d] || tx_active !== 1'b1) && first_bad < 0) begin
               first_bad = pos;
               bad_got   = int'({tx_active, tx_serial});
               bad_exp   = int'({1'b1, cur.bits[pos / cur.d]});
            end
            pos++;
            if (pos == cur.nbits * cur.d) begin
               in_frame = 1'b0;
               done_due = 1'b1;
               chk(first_bad < 0, $sformatf("frame_%02h_sample_%0d", cur.data, first_bad),
                   bad_got, bad_exp);
            end
         end else if (tx_done || tx_active) begin
            chk(!(tx_done || tx_active), "stray_done_active", int'({tx_done, tx_active}), 0);
         end
      end
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [7:0] burst [6];
      int         c, n;
      logic       idle_ok;

      repeat (3) @(negedge clk);
      chk(tx_serial === 1'b1, "reset_serial", int'(tx_serial), 1);
      chk(tx_active === 1'b0 && tx_done === 1'b0 && overflow === 1'b0, "reset_flags",
          int'({tx_active, tx_done, overflow}), 0);
      chk(fifo_count === 3'd0 && tx_ready === 1'b1, "reset_fifo",
          int'({tx_ready, fifo_count}), 4'b1000);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1, D=4, 0xA5
      cfg_cpb = 16'd4; cfg_db = 2'b11; cfg_pen = 1'b0; cfg_podd = 1'b0; cfg_two = 1'b0;
      write_byte(8'hA5, 1);
      drain();

      // 7E2, D=3, 0x53
      cfg_cpb = 16'd3; cfg_db = 2'b10; cfg_pen = 1'b1; cfg_podd = 1'b0; cfg_two = 1'b1;
      write_byte(8'h53, 1);
      drain();

      // 5O1, D=0 (2-cycle bits), 0xFF
      cfg_cpb = 16'd0; cfg_db = 2'b00; cfg_pen = 1'b1; cfg_podd = 1'b1; cfg_two = 1'b0;
      write_byte(8'hFF, 1);
      drain();

      // Six consecutive writes into a 4-deep FIFO, D=10
      cfg_cpb = 16'd10; cfg_db = 2'b11; cfg_pen = 1'b0; cfg_podd = 1'b0; cfg_two = 1'b0;
      burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      c = cyc;
      for (int i = 0; i < 6; i++) begin
         tx_dv   = 1'b1;
         tx_byte = burst[i];
         if (i < 5) exp_q.push_back(mk_frame(burst[i], (i == 0) ? c + 2 : -2));
         @(negedge clk);
         if (i == 4) begin
            chk(fifo_count === 3'd4, "burst_count", int'(fifo_count), 4);
            chk(tx_ready === 1'b0, "burst_ready", int'(tx_ready), 0);
         end
      end
      tx_dv = 1'b0;
      chk(overflow === 1'b1, "overflow_pulse", int'(overflow), 1);
      @(negedge clk);
      chk(overflow === 1'b0, "overflow_one_cycle", int'(overflow), 0);
      drain();

      // Data-bit count changed mid-frame
      cfg_cpb = 16'd4; cfg_db = 2'b11;
      write_byte(8'hC3, 1);
      repeat (12) @(negedge clk);
      cfg_db = 2'b00;
      write_byte(8'h5A, 2);
      drain();

      // Random configurations, small back-to-back groups
      for (int g = 0; g < 12; g++) begin
         cfg_cpb  = 16'($urandom_range(0, 6));
         cfg_db   = 2'($urandom_range(0, 3));
         cfg_pen  = 1'($urandom_range(0, 1));
         cfg_podd = 1'($urandom_range(0, 1));
         cfg_two  = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) write_byte(8'($urandom), (j == 0) ? 1 : 2);
         drain();
      end

      // Reset during DATA with two bytes queued
      cfg_cpb = 16'd8; cfg_db = 2'b11; cfg_pen = 1'b0; cfg_podd = 1'b0; cfg_two = 1'b0;
      write_byte(8'h81, 1);
      write_byte(8'h82, 2);
      write_byte(8'h83, 2);
      repeat (15) @(negedge clk);
      chk(fifo_count === 3'd2, "queued_before_reset", int'(fifo_count), 2);
      #2 rst_n = 1'b0;
      #1;
      chk(tx_serial === 1'b1, "abort_serial", int'(tx_serial), 1);
      chk(fifo_count === 3'd0 && tx_ready === 1'b1, "abort_fifo", int'({tx_ready, fifo_count}), 4'b1000);
      chk(tx_active === 1'b0 && tx_done === 1'b0, "abort_flags", int'({tx_active, tx_done}), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      idle_ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) idle_ok = 1'b0;
      end
      chk(idle_ok, "idle_after_reset", int'(idle_ok), 1);
      write_byte(8'h3C, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKDIV_W, default 16: width of the runtime baud divisor.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, minimum 2.
REQ-003 i_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_RSTN  in  1  reset, asynchronous and active-low.
REQ-005 i_Tx_DV  in  1  write strobe for i_Tx_Byte.
REQ-006 i_Tx_Byte  in  8  data byte; only the low N bits are sent (N = 5..8).
REQ-007 i_Clks_Per_Bit  in  CLKDIV_W  clock cycles per serial bit; values 0 and 1 are treated as 2.
REQ-008 i_Data_Bits  in  2  data-bit count: 00=5, 01=6, 10=7, 11=8.
REQ-009 i_Parity_En  in  1  parity bit enable.
REQ-010 i_Parity_Odd  in  1  1 = odd parity, 0 = even parity.
REQ-011 i_Two_Stop  in  1  1 = two stop bits, 0 = one stop bit.
REQ-012 o_Tx_Ready  out  1  FIFO not full.
REQ-013 o_Tx_Serial  out  1  registered serial line.
REQ-014 o_Tx_Active  out  1  high while a frame is on the line (START through the last STOP bit).
REQ-015 o_Tx_Done  out  1  one-cycle pulse at the end of each frame.
REQ-016 o_Overflow  out  1  one-cycle pulse when a write is dropped.
REQ-017 o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 A write occurs at an edge where i_Tx_DV=1 and o_Tx_Ready=1.
- i_Tx_DV=1 with o_Tx_Ready=0: byte dropped; o_Overflow=1 on the next cycle.
REQ-019 o_Tx_Ready is computed from the registered count only.
- A pop in the same cycle does not permit a write into a full FIFO.
REQ-020 States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Encodings are defined in the shared package.
REQ-021 IDLE, FIFO non-empty:
- pop the head byte;
- latch all five config inputs into frame registers;
- go to START and drive o_Tx_Serial=0 on the same edge.
REQ-022 Config inputs are sampled only at the pop edge; changes mid-frame do not affect the frame in progress.
REQ-023 Every bit is held for exactly the latched divisor D cycles, using a counter that runs 0..D-1 and reloads to 0.
REQ-024 Bit order on the line:
- START: 0;
- DATA: LSB first, N bits;
- PARITY: present only if enabled;
- STOP1: 1;
- STOP2: 1, present only if two stop bits are selected.
REQ-025 Parity bit value:
- even: XOR of the N sent data bits;
- odd: the inverse of that XOR.
- Bits above N do not contribute.
REQ-026 Last stop-bit period ends: o_Tx_Done=1 for exactly one cycle, o_Tx_Active=0, state to IDLE.
REQ-027 Back-to-back frames:
- a non-empty FIFO causes a pop on the first IDLE cycle;
- the line is high for exactly one cycle between frames (after the stop time).
REQ-028 o_Tx_Serial is 1 in IDLE at all times.
REQ-029 Frame length in cycles = D × (1 + N + P + S), where P = 1 if parity is enabled else 0, and S = 2 if two stop bits are selected else 1.
REQ-030 Latency: a write at edge k into an empty FIFO with state IDLE gives o_Tx_Serial=0 after edge k+1.

Reset
REQ-031 Asserting i_RSTN low immediately forces:
- o_Tx_Serial=1;
- o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0;
- FIFO empty (o_Fifo_Count=0, o_Tx_Ready=1);
- state IDLE, counters 0.
REQ-032 Reset mid-frame aborts the frame with no o_Tx_Done pulse; FIFO contents are discarded.
REQ-033 The first frame after deassertion starts only after a new write.

Structure
REQ-034 The shared package uart_pkg holds:
- the state encoding;
- the data-bit-count encoding;
- the minimum divisor constant (2).
REQ-035 The FIFO is a sub-module, uart_tx_fifo, parametrised by depth.
- Ports: push, pop, data, full, empty, count.
- The same clock and reset as the parent.
REQ-036 Bit counter, divisor counter and parity accumulator live in uart_tx_cfg.

Verification
REQ-037 Frame 8N1: D=4, byte 0xA5 -> line bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; Done pulses once after 40 cycles.
REQ-038 Parity and stop bits: 7 data bits, even parity, two stops, D=3, byte 0x53 -> data 1,1,0,0,1,0,1, parity 0, stops 1,1; frame length 33 cycles.
REQ-039 Odd parity with 5 data bits: byte 0xFF -> five 1s, then parity 0.
- Also check D=0 produces 2-cycle bits.
REQ-040 FIFO full and overflow: FIFO_DEPTH=4, write 6 bytes on consecutive cycles with D=10:
- one byte is popped, so 4 are buffered and o_Tx_Ready=0;
- 6th write dropped with an o_Overflow pulse;
- 5 frames are sent in order, each separated by one idle-high cycle.
REQ-041 Config change mid-frame: switch i_Data_Bits from 8 to 5 during DATA -> the current frame still sends 8 bits; the next frame sends 5.
REQ-042 Reset during DATA with 2 bytes queued:
- o_Tx_Serial=1 immediately, Count=0, no Done pulse;
- the line stays idle until a new write.
